data_mem_unit: RTL and testbench
================================

# data_mem_unit

Data-memory stage directly downstream of `MIPS_CPU`. It consumes the CPU's memory-access outputs: `ALU_result` as the address, `Out2` as the store data, and `MemWrite`/`MemtoReg` as the strobes. It returns load data on the path that feeds the CPU's `DataToWd` input. It holds a synchronous word-organised RAM with byte/halfword/word access, a two-cycle load handshake using a stall signal, alignment checking and access counters.

## Interface
- `DEPTH_LOG2`, default 8: RAM holds 2^DEPTH_LOG2 32-bit words.
- `Clock` in 1: single clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `MemRead` in 1: load request (driven from `MemtoReg`).
- `MemWrite` in 1: store request.
- `Size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `LoadSigned` in 1: 1 = sign-extend byte/half loads; 0 = zero-extend.
- `Addr` in 32: byte address (from `ALU_result`).
- `WriteData` in 32: store data (from `Out2`), right-aligned.
- `ReadData` out 32: extended load result (to `DataToWd`).
- `Stall` out 1: CPU must hold PC and request inputs for one more cycle.
- `AddrError` out 1: one-cycle pulse flagging a rejected request.
- `ErrAddr` out 32: address of the most recent rejected request.
- `LoadCount` out 16: completed loads, saturating.
- `StoreCount` out 16: accepted stores, saturating.

## Operation
- **Word index and lanes**
  - Word index is `Addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so the RAM wraps.
  - Byte lane is `Addr[1:0]`. Half lane is `Addr[1]`. Little-endian.
- **FSM states**
  - `IDLE`: accepts requests.
  - `READ`: RAM output valid. Always returns to `IDLE` next cycle.
- **Request legality (`IDLE` only)**
  - A request is illegal if any of these holds:
    - `MemRead` and `MemWrite` are both 1.
    - `Size` = 11.
    - Half access with `Addr[0]` = 1.
    - Word access with `Addr[1:0]` ≠ 00.
  - Illegal request: no RAM access, no stall, counters unchanged, `ErrAddr` <= `Addr`.
  - `AddrError` is high for exactly the next cycle.
- **Store (legal, `IDLE`)**
  - Selected lanes are written at the acceptance edge:
    - byte: `WriteData[7:0]` to lane `Addr[1:0]`
    - half: `WriteData[15:0]` to lane `Addr[1]`
    - word: all four lanes
  - Other lanes are preserved.
  - `Stall` = 0. `StoreCount` increments. State stays `IDLE`.
- **Load (legal, `IDLE`)**
  - `Stall` = 1 combinationally in the acceptance cycle.
  - At the edge: the RAM word is captured into the read register, lane/size/signed are registered, and the state moves to `READ`.
- **`READ` state**
  - `Stall` = 0. `ReadData` = extracted and extended value. Inputs are ignored.
  - At the edge: back to `IDLE`, `LoadCount` increments.
- **ReadData**
  - Always derived from the read register and registered lane/size/signed.
  - Holds its value until the next load capture.
- **Counters**
  - Saturate at 0xFFFF and do not wrap.
- **Reset (async, `Reset` = 0)**
  - State -> `IDLE`; `Stall` = 0.
  - Read register, `ReadData`, `ErrAddr`, `AddrError`, `LoadCount`, `StoreCount` all 0.
  - RAM contents are not cleared.
  - Reset during `READ` abandons the load; `LoadCount` does not increment.

## Timing
- Store: single cycle; the written data is visible to a load accepted on the next cycle.
- Load: 2 cycles.
  - Cycle N: accept, `Stall` = 1.
  - Cycle N+1: `ReadData` valid, `Stall` = 0.
- Store in cycle N followed by a load of the same word in N+1 returns the new data. No bypass is needed because the write completes at edge N.
- Back-to-back loads: second load is accepted in N+2. Throughput is one load per 2 cycles.
- `AddrError`: registered, asserted cycle N+1 for an illegal request in cycle N.
- `Stall` is the only combinational output path, from `MemRead`/`MemWrite`/`Size`/`Addr[1:0]` to `Stall`.

## Test plan
- **Word store/load:** store word 0xDEADBEEF at 0x10, then load word 0x10.
  - `Stall` is 1 for one cycle; next cycle `ReadData` = 0xDEADBEEF.
  - `StoreCount` = 1, `LoadCount` = 1.
- **Byte/half extension:** word 0x80F07F01 at 0x20. Loads and expected `ReadData`:
  - signed byte @0x23 -> 0xFFFFFF80
  - unsigned byte @0x23 -> 0x00000080
  - signed half @0x20 -> 0x00007F01
  - signed half @0x22 -> 0xFFFF80F0
- **Partial store merge:** word 0x11223344 at 0x30, then byte store 0xAA at 0x31, then half store 0xBEEF at 0x32.
  - Word load of 0x30 returns 0xBEEFAA44.
- **Alignment errors:** word load at 0x06, half store at 0x09, `Size` = 11 load at 0x00, and `MemRead` = `MemWrite` = 1.
  - Each gives a one-cycle `AddrError` pulse, `ErrAddr` = that address, no `Stall`, RAM and counters unchanged.
- **Wrap and reset:** with `DEPTH_LOG2` = 8, store 0x5 at 0x400 and load 0x000 -> 0x5.
  - Assert `Reset` low during `READ`: `Stall` = 0, `ReadData` = 0, counters = 0.
  - After release, a load of 0x000 still returns 0x5.
- **Saturation:** 65 540 stores -> `StoreCount` holds at 0xFFFF.

Source files
------------

// File: rtl/data_mem_unit.sv
// Data-memory stage behind the CPU: byte/half/word RAM with a two-cycle
// load handshake, alignment rejection and saturating access counters.
module data_mem_unit #(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  Size,
   input  logic        LoadSigned,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AddrError,
   output logic [31:0] ErrAddr,
   output logic [15:0] LoadCount,
   output logic [15:0] StoreCount
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] READ = 1'b1;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   logic [31:0] mem [DEPTH];

   logic [0:0]  state_q, state_d;
   logic [31:0] rd_q, rd_d;
   logic [1:0]  lane_q, lane_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic        err_q, err_d;
   logic [31:0] err_addr_q, err_addr_d;
   logic [15:0] ld_cnt_q, ld_cnt_d;
   logic [15:0] st_cnt_q, st_cnt_d;

   logic [DEPTH_LOG2-1:0] idx;
   logic        idle;
   logic        req;
   logic        mis;
   logic        illegal;
   logic        ld_go;
   logic        st_go;
   logic [3:0]  be;
   logic [31:0] wword;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      idx  = Addr[DEPTH_LOG2+1:2];
      idle = (state_q == IDLE);
      req  = MemRead | MemWrite;
      unique case (Size)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = Addr[0];
         SZ_W:    mis = |Addr[1:0];
         default: mis = 1'b1;
      endcase
      illegal = (MemRead & MemWrite) | mis;
      ld_go   = idle & MemRead & ~illegal;
      st_go   = idle & MemWrite & ~illegal;
   end

   assign Stall = ld_go;

   // Lane data is replicated so the byte enables alone pick the target lanes.
   always_comb begin
      be    = 4'b0000;
      wword = WriteData;
      unique case (Size)
         SZ_B: begin
            be    = 4'b0001 << Addr[1:0];
            wword = {4{WriteData[7:0]}};
         end
         SZ_H: begin
            be    = Addr[1] ? 4'b1100 : 4'b0011;
            wword = {2{WriteData[15:0]}};
         end
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (st_go) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      lane_d     = lane_q;
      size_d     = size_q;
      sgn_d      = sgn_q;
      err_d      = 1'b0;
      err_addr_d = err_addr_q;
      ld_cnt_d   = ld_cnt_q;
      st_cnt_d   = st_cnt_q;
      if (state_q == READ) begin
         state_d = IDLE;
         if (ld_cnt_q != 16'hFFFF) ld_cnt_d = ld_cnt_q + 16'd1;
      end else if (req && illegal) begin
         err_d      = 1'b1;
         err_addr_d = Addr;
      end else if (ld_go) begin
         state_d = READ;
         rd_d    = mem[idx];
         lane_d  = Addr[1:0];
         size_d  = Size;
         sgn_d   = LoadSigned;
      end else if (st_go) begin
         if (st_cnt_q != 16'hFFFF) st_cnt_d = st_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         rd_q       <= '0;
         lane_q     <= '0;
         size_q     <= '0;
         sgn_q      <= 1'b0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
         ld_cnt_q   <= '0;
         st_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         lane_q     <= lane_d;
         size_q     <= size_d;
         sgn_q      <= sgn_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
         ld_cnt_q   <= ld_cnt_d;
         st_cnt_q   <= st_cnt_d;
      end
   end

   always_comb begin
      unique case (lane_q)
         2'd0:    byte_v = rd_q[7:0];
         2'd1:    byte_v = rd_q[15:8];
         2'd2:    byte_v = rd_q[23:16];
         default: byte_v = rd_q[31:24];
      endcase
      half_v = lane_q[1] ? rd_q[31:16] : rd_q[15:0];
      unique case (size_q)
         SZ_B:    ReadData = {{24{sgn_q & byte_v[7]}}, byte_v};
         SZ_H:    ReadData = {{16{sgn_q & half_v[15]}}, half_v};
         default: ReadData = rd_q;
      endcase
   end

   assign AddrError  = err_q;
   assign ErrAddr    = err_addr_q;
   assign LoadCount  = ld_cnt_q;
   assign StoreCount = st_cnt_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: loads, stores, merges, alignment
// rejection, address wrap, reset during a load and counter saturation.
module tb_data_mem_unit;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [1:0]  Size = 2'b00;
   logic        LoadSigned = 1'b0;
   logic [31:0] Addr = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        Stall;
   logic        AddrError;
   logic [31:0] ErrAddr;
   logic [15:0] LoadCount;
   logic [15:0] StoreCount;

   int total = 0;
   int bad = 0;

   data_mem_unit #(.DEPTH_LOG2(8)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .MemRead(MemRead),
      .MemWrite(MemWrite),
      .Size(Size),
      .LoadSigned(LoadSigned),
      .Addr(Addr),
      .WriteData(WriteData),
      .ReadData(ReadData),
      .Stall(Stall),
      .AddrError(AddrError),
      .ErrAddr(ErrAddr),
      .LoadCount(LoadCount),
      .StoreCount(StoreCount)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz);
      MemRead   = 1'b0;
      MemWrite  = 1'b1;
      Size      = sz;
      Addr      = a;
      WriteData = d;
      #1;
      chk("store_stall", {31'd0, Stall}, 32'd0);
      cyc();
      idle();
   endtask

   task automatic load(input string tag, input logic [31:0] a,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] exp);
      MemRead    = 1'b1;
      MemWrite   = 1'b0;
      Size       = sz;
      LoadSigned = sg;
      Addr       = a;
      #1;
      chk({tag, "_stall1"}, {31'd0, Stall}, 32'd1);
      cyc();
      idle();
      #1;
      chk({tag, "_stall0"}, {31'd0, Stall}, 32'd0);
      chk(tag, ReadData, exp);
      cyc();
   endtask

   task automatic bad_req(input string tag, input logic rd, input logic wr,
                          input logic [1:0] sz, input logic [31:0] a);
      MemRead   = rd;
      MemWrite  = wr;
      Size      = sz;
      Addr      = a;
      WriteData = 32'hFFFF_FFFF;
      #1;
      chk({tag, "_stall"}, {31'd0, Stall}, 32'd0);
      cyc();
      idle();
      chk({tag, "_err"}, {31'd0, AddrError}, 32'd1);
      chk({tag, "_eaddr"}, ErrAddr, a);
      cyc();
      chk({tag, "_errdrop"}, {31'd0, AddrError}, 32'd0);
   endtask

   initial begin
      #2;
      chk("rst_rdata", ReadData, 32'd0);
      chk("rst_stall", {31'd0, Stall}, 32'd0);
      chk("rst_err", {31'd0, AddrError}, 32'd0);
      chk("rst_eaddr", ErrAddr, 32'd0);
      chk("rst_lcnt", {16'd0, LoadCount}, 32'd0);
      chk("rst_scnt", {16'd0, StoreCount}, 32'd0);
      cyc();
      cyc();
      Reset = 1'b1;
      cyc();

      store(32'h10, 32'hDEADBEEF, 2'b10);
      chk("scnt1", {16'd0, StoreCount}, 32'd1);
      load("lw10", 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
      chk("lcnt1", {16'd0, LoadCount}, 32'd1);

      store(32'h20, 32'h80F07F01, 2'b10);
      load("lb23s", 32'h23, 2'b00, 1'b1, 32'hFFFFFF80);
      load("lb23u", 32'h23, 2'b00, 1'b0, 32'h00000080);
      load("lh20s", 32'h20, 2'b01, 1'b1, 32'h00007F01);
      load("lh22s", 32'h22, 2'b01, 1'b1, 32'hFFFF80F0);
      load("lh22u", 32'h22, 2'b01, 1'b0, 32'h000080F0);
      load("lb21s", 32'h21, 2'b00, 1'b1, 32'h0000007F);

      store(32'h30, 32'h11223344, 2'b10);
      store(32'h31, 32'h000000AA, 2'b00);
      store(32'h32, 32'h0000BEEF, 2'b01);
      load("merge", 32'h30, 2'b10, 1'b0, 32'hBEEFAA44);
      load("hold", 32'h30, 2'b10, 1'b0, 32'hBEEFAA44);
      chk("rd_hold", ReadData, 32'hBEEFAA44);

      store(32'h08, 32'h12345678, 2'b10);
      chk("scnt6", {16'd0, StoreCount}, 32'd6);
      chk("lcnt9", {16'd0, LoadCount}, 32'd9);
      bad_req("lw06", 1'b1, 1'b0, 2'b10, 32'h06);
      bad_req("sh09", 1'b0, 1'b1, 2'b01, 32'h09);
      bad_req("sz11", 1'b1, 1'b0, 2'b11, 32'h00);
      bad_req("rdwr", 1'b1, 1'b1, 2'b10, 32'h30);
      chk("err_scnt", {16'd0, StoreCount}, 32'd6);
      chk("err_lcnt", {16'd0, LoadCount}, 32'd9);
      load("keep08", 32'h08, 2'b10, 1'b0, 32'h12345678);
      load("keep30", 32'h30, 2'b10, 1'b0, 32'hBEEFAA44);

      store(32'h400, 32'h5, 2'b10);
      load("wrap", 32'h000, 2'b10, 1'b0, 32'h5);

      MemRead = 1'b1;
      Size    = 2'b10;
      Addr    = 32'h0;
      #1;
      chk("rr_stall1", {31'd0, Stall}, 32'd1);
      cyc();
      idle();
      Reset = 1'b0;
      #1;
      chk("rr_stall", {31'd0, Stall}, 32'd0);
      chk("rr_rdata", ReadData, 32'd0);
      chk("rr_lcnt", {16'd0, LoadCount}, 32'd0);
      chk("rr_scnt", {16'd0, StoreCount}, 32'd0);
      cyc();
      Reset = 1'b1;
      cyc();
      chk("rr_lcnt2", {16'd0, LoadCount}, 32'd0);
      load("post_rst", 32'h000, 2'b10, 1'b0, 32'h5);
      chk("post_lcnt", {16'd0, LoadCount}, 32'd1);

      MemWrite  = 1'b1;
      Size      = 2'b10;
      Addr      = 32'h40;
      WriteData = 32'hA5A5A5A5;
      repeat (65534) cyc();
      chk("sat_m1", {16'd0, StoreCount}, 32'h0000FFFE);
      cyc();
      chk("sat", {16'd0, StoreCount}, 32'h0000FFFF);
      repeat (5) cyc();
      idle();
      chk("sat_hold", {16'd0, StoreCount}, 32'h0000FFFF);
      load("sat_data", 32'h40, 2'b10, 1'b0, 32'hA5A5A5A5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
